airi5c_hasti_arbiter: RTL



---
 rtl/airi5c_hasti_arbiter_if.sv | 24 ++
 rtl/airi5c_hasti_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/airi5c_hasti_arbiter_if.sv
// AHB-Lite (HASTI) master-port bundle shared by the imem/dmem arbiter and its slave.
interface airi5c_hasti_arbiter_if;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/airi5c_hasti_arbiter.sv
// Two-requester (imem/dmem) to one AHB-Lite master-port arbiter with pipelined owner tracking.
// Optional round-robin on simultaneous requests: define AIRI5C_ARB_ROUND_ROBIN_EN (default: dmem priority).
module airi5c_hasti_arbiter #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        nreset,

    input  logic        imem_en,
    input  logic        imem_wen,
    input  logic [2:0]  imem_size,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata_delayed,
    output logic [31:0] imem_rdata,
    output logic        imem_wait,
    output logic        imem_badmem_e,

    input  logic        dmem_en,
    input  logic        dmem_wen,
    input  logic [2:0]  dmem_size,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata_delayed,
    output logic [31:0] dmem_rdata,
    output logic        dmem_wait,
    output logic        dmem_badmem_e,

    airi5c_hasti_arbiter_if.master bus
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic       PORT_IMEM     = 1'b0;
    localparam logic       PORT_DMEM     = 1'b1;

    logic grant_q, aval_q, downer_q, dval_q;
    logic arb_grant, grant, grant_en, hold, err_first, addr_active;
    logic imem_owner, dmem_owner;

    // A stalled data phase freezes the address/control currently on the bus.
    assign hold      = ~bus.hready & aval_q;
    // First error cycle: the slave wants the pending address phase withdrawn.
    assign err_first = dval_q & bus.hresp & ~bus.hready;

`ifdef AIRI5C_ARB_ROUND_ROBIN_EN
    logic last_q;

    assign arb_grant = (imem_en & dmem_en) ? ~last_q : dmem_en;

    always_ff @(posedge clk) begin
        if (!nreset)
            last_q <= PORT_IMEM;
        else if (bus.hready && addr_active)
            last_q <= grant;
    end
`else
    assign arb_grant = dmem_en;
`endif

    assign grant       = hold ? grant_q : arb_grant;
    assign grant_en    = (grant == PORT_DMEM) ? dmem_en : imem_en;
    assign addr_active = grant_en & ~err_first;

    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            grant_q  <= PORT_IMEM;
            aval_q   <= 1'b0;
            downer_q <= PORT_IMEM;
            dval_q   <= 1'b0;
        end else if (bus.hready) begin
            grant_q  <= grant;
            aval_q   <= addr_active;
            downer_q <= grant;
            dval_q   <= addr_active;
        end else if (err_first) begin
            aval_q   <= 1'b0;
        end
    end

    assign bus.haddr     = (grant == PORT_DMEM) ? dmem_addr : imem_addr;
    assign bus.hwrite    = (grant == PORT_DMEM) ? dmem_wen  : imem_wen;
    assign bus.hsize     = (grant == PORT_DMEM) ? dmem_size : imem_size;
    assign bus.htrans    = addr_active ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.hburst    = HBURST_SINGLE;
    assign bus.hmastlock = 1'b0;
    assign bus.hprot     = 4'b0011;
    assign bus.hwdata    = !dval_q ? '0 :
                           (downer_q == PORT_DMEM) ? dmem_wdata_delayed : imem_wdata_delayed;

    assign imem_owner = dval_q & (downer_q == PORT_IMEM);
    assign dmem_owner = dval_q & (downer_q == PORT_DMEM);

    assign imem_rdata = imem_owner ? bus.hrdata : NOP_WORD;
    assign dmem_rdata = dmem_owner ? bus.hrdata : NOP_WORD;

    // Stall when denied, when our data phase is stretched, or when granted behind someone else's stall.
    assign imem_wait = (imem_en & (grant != PORT_IMEM))
                     | (imem_owner & ~bus.hready)
                     | (imem_en & (grant == PORT_IMEM) & ~bus.hready & ~imem_owner);
    assign dmem_wait = (dmem_en & (grant != PORT_DMEM))
                     | (dmem_owner & ~bus.hready)
                     | (dmem_en & (grant == PORT_DMEM) & ~bus.hready & ~dmem_owner);

    assign imem_badmem_e = imem_owner & bus.hresp;
    assign dmem_badmem_e = dmem_owner & bus.hresp;

endmodule
